// File: rtl/channel_deinterleaver.sv
// Block deinterleaver: collects a frame of column-major serial bits into a row-major
// matrix and presents the non-filler payload as one parallel word with a filler-error flag.
module channel_deinterleaver #(
  parameter int N_SYM   = 7,
  parameter int N_SC    = 1,
  parameter int N_RU    = 1,
  parameter int QM      = 2,
  parameter int N_SLOTS = 2,
  parameter int K_OUT   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_sof,
  output logic             in_ready,
  output logic [K_OUT-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             filler_err
);

  localparam int N_COL = (N_SYM - 1) * N_SLOTS;
  localparam int N_ROW = N_SC * N_RU * QM;
  localparam int TOTAL = N_ROW * N_COL;
  localparam int RW    = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam int CW    = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam int PW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef enum logic {LOAD, HOLD} state_t;

  state_t           state_reg;
  logic [RW-1:0]    row_reg;
  logic [CW-1:0]    col_reg;
  logic [K_OUT-1:0] frame_reg;
  logic             err_acc_reg;

  logic             accept;
  logic [RW-1:0]    row_eff;
  logic [CW-1:0]    col_eff;
  logic [PW-1:0]    pos;
  logic             last_beat;
  logic             beat_filler;
  logic             err_next;
  logic [K_OUT-1:0] frame_next;
  logic [K_OUT-1:0] payload;

  // An accepted start-of-frame beat is always beat 0, regardless of the counters.
  assign accept      = in_valid && (state_reg == LOAD);
  assign row_eff     = in_sof ? '0 : row_reg;
  assign col_eff     = in_sof ? '0 : col_reg;
  assign pos         = PW'(row_eff) * PW'(N_COL) + PW'(col_eff);
  assign last_beat   = (row_eff == RW'(N_ROW - 1)) && (col_eff == CW'(N_COL - 1));
  assign beat_filler = ({1'b0, pos} >= (PW+1)'(K_OUT));
  assign err_next    = (in_sof ? 1'b0 : err_acc_reg) | (beat_filler & in_bit);

  // frame_next is indexed by row-major position; payload flips it so position 0 is the MSB.
  generate
    for (genvar gi = 0; gi < K_OUT; gi++) begin : g_pos
      assign frame_next[gi]          = (accept && (pos == PW'(gi))) ? in_bit : frame_reg[gi];
      assign payload[K_OUT - 1 - gi] = frame_next[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= LOAD;
      row_reg     <= '0;
      col_reg     <= '0;
      frame_reg   <= '0;
      err_acc_reg <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      data_out    <= '0;
      filler_err  <= 1'b0;
    end else if (state_reg == LOAD) begin
      if (accept) begin
        frame_reg <= frame_next;
        if (last_beat) begin
          state_reg   <= HOLD;
          row_reg     <= '0;
          col_reg     <= '0;
          err_acc_reg <= 1'b0;
          in_ready    <= 1'b0;
          out_valid   <= 1'b1;
          data_out    <= payload;
          filler_err  <= err_next;
        end else begin
          err_acc_reg <= err_next;
          // Column-major walk: rows advance fastest, the column steps when a column fills.
          if (row_eff == RW'(N_ROW - 1)) begin
            row_reg <= '0;
            col_reg <= col_eff + CW'(1);
          end else begin
            row_reg <= row_eff + RW'(1);
            col_reg <= col_eff;
          end
        end
      end
    end else begin
      if (out_ready) begin
        state_reg   <= LOAD;
        row_reg     <= '0;
        col_reg     <= '0;
        err_acc_reg <= 1'b0;
        in_ready    <= 1'b1;
        out_valid   <= 1'b0;
        filler_err  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/channel_deinterleaver.md
CHANNEL_DEINTERLEAVER -- requirements
Module: channel_deinterleaver

Interface
REQ-001 SHALL provide parameter N_SYM, default 7, SC-FDMA symbols per slot.
REQ-002 SHALL provide parameter N_SC, default 1, subcarriers.
REQ-003 SHALL provide parameter N_RU, default 1, resource units.
REQ-004 SHALL provide parameter QM, default 2, modulation order.
REQ-005 SHALL provide parameter N_SLOTS, default 2, slots.
REQ-006 SHALL provide parameter K_OUT, default 16, payload bits per frame; legal range is 1 to N_ROW*N_COL.
REQ-007 SHALL derive N_COL=(N_SYM-1)*N_SLOTS (12), N_ROW=N_SC*N_RU*QM (2) and TOTAL=N_ROW*N_COL (24) as local constants.
REQ-008 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-009 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-010 SHALL have port in_valid, input, 1 bit, in_bit is valid.
REQ-011 SHALL have port in_bit, input, 1 bit, serial interleaved bit in column-major order.
REQ-012 SHALL have port in_sof, input, 1 bit, start of frame, qualified by in_valid.
REQ-013 SHALL have port in_ready, output, 1 bit, block accepts an input beat.
REQ-014 SHALL have port data_out, output, K_OUT bits, deinterleaved payload; the first row-major bit is placed on the MSB.
REQ-015 SHALL have port out_valid, output, 1 bit, data_out is valid.
REQ-016 SHALL have port out_ready, input, 1 bit, downstream accepts data_out.
REQ-017 SHALL have port filler_err, output, 1 bit, a filler position held a 1 in the frame on data_out; valid with out_valid.

Function
REQ-018 SHALL implement two states: LOAD (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-019 SHALL accept an input beat only on a cycle with in_valid=1 and in_ready=1.
REQ-020 SHALL store accepted beat number n (0..TOTAL-1) at row n mod N_ROW, column n div N_COL... correction: column n div N_ROW; this is the inverse of the row-write/column-read transmit interleaver.
REQ-021 SHALL map the matrix row-major: position p=row*N_COL+col, and SHALL drive data_out[K_OUT-1-p]=stored bit for every p<K_OUT.
REQ-022 SHALL treat positions p>=K_OUT as filler: the bit is discarded from data_out, and filler_err is set if that bit is 1.
REQ-023 SHALL, on an accepted beat with in_sof=1, treat that beat as n=0 and clear the filler_err accumulator, abandoning any partial frame.
REQ-024 SHALL ignore in_sof when it is not accepted (in_valid=0 or state HOLD).
REQ-025 SHALL, when beat n=TOTAL-1 is accepted, enter HOLD on the next cycle with data_out and filler_err reflecting the complete frame; latency is 1 cycle from the last accepted beat to out_valid.
REQ-026 SHALL hold data_out, filler_err and out_valid stable in HOLD until out_ready=1.
REQ-027 SHALL, on the cycle with out_valid=1 and out_ready=1, return to LOAD on the next cycle with n=0 and the filler_err accumulator cleared.
REQ-028 SHALL NOT accept a beat in the same cycle as an output handshake (in_ready=0 throughout HOLD).
REQ-029 SHALL wrap the beat counter only via frame completion, in_sof, or reset; it SHALL never exceed TOTAL-1.
REQ-030 SHALL retain the data_out value of the last completed frame while in LOAD; that value is don't-care to consumers.

Reset
REQ-031 SHALL, when reset=1 at a clock edge, enter LOAD with n=0, out_valid=0, in_ready=1 on the next cycle, and filler_err=0.
REQ-032 SHALL reset data_out to all zeros.
REQ-033 SHALL give reset priority over all other inputs, including reset asserted mid-frame or in HOLD; the partial frame is discarded.

Verification
REQ-034 Bench SHALL drive 24 beats with only n=0 set (in_sof on n=0) -> data_out=16'h8000, filler_err=0, out_valid 1 cycle after the last beat.
REQ-035 Bench SHALL drive only n=1 set -> data_out=16'h0008; then only n=2 set -> data_out=16'h4000.
REQ-036 Bench SHALL drive only n=23 set -> data_out=16'h0000, filler_err=1; the next all-zero frame -> filler_err=0.
REQ-037 Bench SHALL hold out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, no beats consumed, data_out stable; with out_ready=1, LOAD is entered the next cycle.
REQ-038 Bench SHALL assert in_sof at n=10 with a new frame, and separately reset at n=10 -> output equals only the restarted frame, with no stale bits.
REQ-039 Bench SHALL send a random 16-bit payload through a golden interleaver model with random in_valid gaps -> data_out equals the payload for 100 frames.
